// File: rtl/lc3_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// lc3_mem_port_arbiter
//
// Purpose:
//   Shares one single-port unified memory between the fetch stage (instruction
//   requester) and the execute stage (data requester: LD/LDR, ST/STR, LDI, STI).
//   Indirect accesses (LDI/STI) run as two memory phases: a pointer read
//   followed by the real access at the pointer. Data requests win arbitration,
//   but after MAX_WAIT consecutive data grants with a fetch pending, the fetch
//   wins once.
//
// Ports:
//   clk, rst                clock (rising edge), asynchronous active-low reset
//   instr_req/instr_addr    fetch request (level) and PC
//   instr_dout              fetched word, valid while complete_instr=1
//   complete_instr          one-cycle fetch completion pulse
//   data_req/data_op        data request (level); op 00 rd, 01 wr, 10 LDI, 11 STI
//   data_addr/data_din      effective (or pointer) address and store data
//   data_dout               load data, valid while complete_data=1
//   complete_data           one-cycle data completion pulse
//   mem_state               0 data read, 1 pointer read, 2 data write, 3 idle/fetch
//   mem_en/mem_we           memory strobe and write enable
//   mem_addr/mem_wdata      memory address and write data
//   mem_rdata/mem_ack       memory read data and access-done handshake
// ----------------------------------------------------------------------------
module lc3_mem_port_arbiter #(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [DATA_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr_dout,
  output logic              complete_instr,
  input  logic              data_req,
  input  logic [1:0]        data_op,
  input  logic [DATA_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_din,
  output logic [DATA_W-1:0] data_dout,
  output logic              complete_data,
  output logic [1:0]        mem_state,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_I_ACC = 3'd1,
    ST_D_PTR = 3'd2,
    ST_D_ACC = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_PTR   = 2'd1;
  localparam logic [1:0] MS_WRITE = 2'd2;
  localparam logic [1:0] MS_IDLE  = 2'd3;

  state_t            r_state;
  logic              r_is_data;     // the transaction in flight belongs to the data port
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_iaddr;
  logic [DATA_W-1:0] r_daddr;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_ptr;
  logic [3:0]        r_wait_cnt;
  logic [DATA_W-1:0] r_instr_dout;
  logic [DATA_W-1:0] r_data_dout;
  logic [1:0]        r_mem_state;

  logic              w_grant_data;
  logic [DATA_W-1:0] w_mem_addr;

  // Data wins unless a fetch has been waiting through MAX_WAIT data grants.
  assign w_grant_data = data_req && (!instr_req || (r_wait_cnt < MAX_WAIT_C));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_is_data    <= 1'b0;
      r_op         <= 2'b00;
      r_iaddr      <= '0;
      r_daddr      <= '0;
      r_din        <= '0;
      r_ptr        <= '0;
      r_wait_cnt   <= 4'd0;
      r_instr_dout <= '0;
      r_data_dout  <= '0;
      r_mem_state  <= MS_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_data) begin
            r_is_data <= 1'b1;
            r_op      <= data_op;
            r_daddr   <= data_addr;
            r_din     <= data_din;
            if (instr_req && (r_wait_cnt < MAX_WAIT_C)) begin
              r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            if (data_op[1]) begin
              r_state     <= ST_D_PTR;
              r_mem_state <= MS_PTR;
            end else begin
              r_state     <= ST_D_ACC;
              r_mem_state <= data_op[0] ? MS_WRITE : MS_READ;
            end
          end else if (instr_req) begin
            r_is_data   <= 1'b0;
            r_iaddr     <= instr_addr;
            r_wait_cnt  <= 4'd0;
            r_state     <= ST_I_ACC;
            r_mem_state <= MS_IDLE;
          end else begin
            r_mem_state <= MS_IDLE;
          end
        end
        ST_I_ACC: begin
          if (mem_ack) begin
            r_instr_dout <= mem_rdata;
            r_state      <= ST_RESP;
          end
        end
        ST_D_PTR: begin
          if (mem_ack) begin
            r_ptr       <= mem_rdata;
            r_state     <= ST_D_ACC;
            r_mem_state <= r_op[0] ? MS_WRITE : MS_READ;
          end
        end
        ST_D_ACC: begin
          if (mem_ack) begin
            if (!r_op[0]) begin
              r_data_dout <= mem_rdata;
            end
            // mem_state keeps the data code through RESP
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_mem_state <= MS_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mem_state <= MS_IDLE;
        end
      endcase
    end
  end

  // Address is a pure function of state and latched fields, so it stays
  // stable for the whole access regardless of requester activity.
  always_comb begin
    w_mem_addr = '0;
    case (r_state)
      ST_I_ACC: w_mem_addr = r_iaddr;
      ST_D_PTR: w_mem_addr = r_daddr;
      ST_D_ACC: w_mem_addr = r_op[1] ? r_ptr : r_daddr;
      default:  w_mem_addr = '0;
    endcase
  end

  assign mem_addr       = w_mem_addr;
  assign mem_en         = (r_state == ST_I_ACC) || (r_state == ST_D_PTR) || (r_state == ST_D_ACC);
  assign mem_we         = (r_state == ST_D_ACC) && r_op[0];
  assign mem_wdata      = r_din;
  assign mem_state      = r_mem_state;
  assign complete_instr = (r_state == ST_RESP) && !r_is_data;
  assign complete_data  = (r_state == ST_RESP) && r_is_data;
  assign instr_dout     = r_instr_dout;
  assign data_dout      = r_data_dout;

endmodule

// File: tb/tb_lc3_mem_port_arbiter.sv
module tb_lc3_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_req = 1'b0;
  logic [15:0] instr_addr = '0;
  logic [15:0] instr_dout;
  logic        complete_instr;
  logic        data_req = 1'b0;
  logic [1:0]  data_op = 2'b00;
  logic [15:0] data_addr = '0;
  logic [15:0] data_din = '0;
  logic [15:0] data_dout;
  logic        complete_data;
  logic [1:0]  mem_state;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  lc3_mem_port_arbiter #(.DATA_W(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_dout(instr_dout),
    .complete_instr(complete_instr),
    .data_req(data_req), .data_op(data_op), .data_addr(data_addr), .data_din(data_din),
    .data_dout(data_dout), .complete_data(complete_data),
    .mem_state(mem_state), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: ack arrives after 'lat' extra cycles of mem_en.
  logic [15:0] tmem [0:65535];
  int lat = 0;
  int ack_cnt = 0;
  assign mem_ack   = mem_en && (ack_cnt >= lat);
  assign mem_rdata = tmem[mem_addr];
  always @(posedge clk) begin
    if (!rst || !mem_en || mem_ack) ack_cnt <= 0;
    else ack_cnt <= ack_cnt + 1;
    if (rst && mem_en && mem_we && mem_ack) tmem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          fetch;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] din;
    int          lat;
    logic [15:0] exp_dout;
    int          exp_cyc;
    int          exp_nacc;
    logic [1:0]  exp_st0;
    logic [15:0] exp_ad0;
    logic [1:0]  exp_st1;
    logic [15:0] exp_ad1;
    logic [1:0]  exp_resp_st;
    bit          wchk;
    logic [15:0] waddr;
    logic [15:0] wval;
  } vec_t;

  vec_t vecs [6];

  // Called at a negedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int na;
    bit got;
    logic [1:0]  st [2];
    logic [15:0] ad [2];
    logic [15:0] dout;
    lat = v.lat;
    if (v.fetch) begin
      instr_req = 1'b1; instr_addr = v.addr;
    end else begin
      data_req = 1'b1; data_op = v.op; data_addr = v.addr; data_din = v.din;
    end
    @(posedge clk); #1;
    // Scramble request fields after grant; the DUT must use its latched copy.
    instr_req = 1'b0; data_req = 1'b0; data_addr = 16'hFFFF; instr_addr = 16'hFFFF; data_din = 16'h0;
    n = 0; na = 0; got = 1'b0;
    st[0] = 2'bxx; st[1] = 2'bxx; ad[0] = 'x; ad[1] = 'x;
    while (!got && n < 40) begin
      @(negedge clk); n++;
      if (mem_en && mem_ack && na < 2) begin st[na] = mem_state; ad[na] = mem_addr; na++; end
      if (complete_instr || complete_data) got = 1'b1;
    end
    chk($sformatf("v%0d_done", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d_kind", idx), {30'd0, complete_instr, complete_data}, {30'd0, v.fetch, !v.fetch});
    dout = v.fetch ? instr_dout : data_dout;
    chk($sformatf("v%0d_dout", idx), 32'(dout), 32'(v.exp_dout));
    chk($sformatf("v%0d_cycles", idx), 32'(n + 1), 32'(v.exp_cyc));
    chk($sformatf("v%0d_naccess", idx), 32'(na), 32'(v.exp_nacc));
    chk($sformatf("v%0d_state0", idx), 32'(st[0]), 32'(v.exp_st0));
    chk($sformatf("v%0d_addr0", idx), 32'(ad[0]), 32'(v.exp_ad0));
    if (v.exp_nacc == 2) begin
      chk($sformatf("v%0d_state1", idx), 32'(st[1]), 32'(v.exp_st1));
      chk($sformatf("v%0d_addr1", idx), 32'(ad[1]), 32'(v.exp_ad1));
    end
    chk($sformatf("v%0d_resp_state", idx), 32'(mem_state), 32'(v.exp_resp_st));
    @(negedge clk);
    chk($sformatf("v%0d_idle", idx), {28'd0, mem_state, mem_en, complete_instr | complete_data}, {28'd0, 2'd3, 1'b0, 1'b0});
    if (v.wchk) chk($sformatf("v%0d_memwrite", idx), 32'(tmem[v.waddr]), 32'(v.wval));
    $display("txn %0d: fetch=%0d op=%0d addr=%h dout=%h cycles=%0d", idx, v.fetch, v.op, v.addr, dout, n + 1);
  endtask

  initial begin
    int g;
    int cyc;
    bit prev_en;
    bit got;

    for (int i = 0; i < 65536; i++) tmem[i] = 16'h0000;
    tmem[16'h3000] = 16'h1261;
    tmem[16'h3001] = 16'hF025;
    tmem[16'h1234] = 16'hCAFE;
    tmem[16'h4000] = 16'h5000;
    tmem[16'h5000] = 16'hBEEF;
    tmem[16'h4100] = 16'h6000;

    //          fetch op     addr      din       lat dout      cyc na st0   ad0       st1   ad1       resp  wchk waddr     wval
    vecs[0] = '{1'b1, 2'b00, 16'h3000, 16'h0000, 1, 16'h1261, 4, 1, 2'd3, 16'h3000, 2'd3, 16'h0000, 2'd3, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 2'b00, 16'h1234, 16'h0000, 0, 16'hCAFE, 3, 1, 2'd0, 16'h1234, 2'd0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 2'b01, 16'h2222, 16'h5A5A, 2, 16'hCAFE, 5, 1, 2'd2, 16'h2222, 2'd0, 16'h0000, 2'd2, 1'b1, 16'h2222, 16'h5A5A};
    vecs[3] = '{1'b0, 2'b10, 16'h4000, 16'h0000, 0, 16'hBEEF, 4, 2, 2'd1, 16'h4000, 2'd0, 16'h5000, 2'd0, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{1'b0, 2'b11, 16'h4100, 16'h00AA, 1, 16'hBEEF, 6, 2, 2'd1, 16'h4100, 2'd2, 16'h6000, 2'd2, 1'b1, 16'h6000, 16'h00AA};
    vecs[5] = '{1'b1, 2'b00, 16'h3001, 16'h0000, 0, 16'hF025, 3, 1, 2'd3, 16'h3001, 2'd3, 16'h0000, 2'd3, 1'b0, 16'h0000, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {mem_state, mem_en, mem_we, complete_instr, complete_data},
        {2'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_douts", {instr_dout, data_dout}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    $display("txn reset: mem_state=%0d mem_en=%0d", mem_state, mem_en);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Simultaneous requests: data first, then fetch in the IDLE after data RESP
    lat = 0;
    instr_req = 1'b1; instr_addr = 16'h3000;
    data_req = 1'b1; data_op = 2'b00; data_addr = 16'h1234;
    @(posedge clk); #1 data_req = 1'b0;
    @(negedge clk);
    chk("simul_first_is_data", {mem_en, mem_state, mem_addr}, {1'b1, 2'd0, 16'h1234});
    @(negedge clk);
    chk("simul_data_done", 32'(complete_data), 32'd1);
    @(negedge clk);
    chk("simul_idle_between", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("simul_fetch_next", {mem_en, mem_we, mem_state, mem_addr}, {1'b1, 1'b0, 2'd3, 16'h3000});
    instr_req = 1'b0;
    @(negedge clk);
    chk("simul_fetch_done", {15'd0, complete_instr, instr_dout}, {15'd0, 1'b1, 16'h1261});
    @(negedge clk);
    $display("txn simultaneous: data then fetch");

    // Starvation: both held high; expect D D D D I D D D D I
    instr_addr = 16'h3000; data_addr = 16'h1234; data_op = 2'b00;
    instr_req = 1'b1; data_req = 1'b1;
    g = 0; cyc = 0; prev_en = 1'b0;
    while (g < 10 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (mem_en && !prev_en) begin
        chk($sformatf("starve_grant%0d_is_fetch", g), 32'(mem_state == 2'd3),
            32'((g == 4) || (g == 9)));
        $display("txn starve grant %0d: mem_state=%0d addr=%h", g, mem_state, mem_addr);
        g++;
      end
      prev_en = mem_en;
    end
    chk("starve_all_grants_seen", 32'(g), 32'd10);
    instr_req = 1'b0; data_req = 1'b0;
    repeat (4) @(negedge clk);

    // Reset mid D_ACC
    lat = 6;
    data_req = 1'b1; data_op = 2'b00; data_addr = 16'h1234;
    @(posedge clk); #1 data_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_in_access", {mem_en, mem_state}, {1'b1, 2'd0});
    rst = 1'b0;
    #1;
    chk("midreset_outputs", {mem_en, mem_state, complete_instr, complete_data},
        {1'b0, 2'd3, 1'b0, 1'b0});
    chk("midreset_douts", {instr_dout, data_dout}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("after_reset_idle", {mem_en, mem_state}, {1'b0, 2'd3});
    $display("txn mid-access reset");
    run_vec(vecs[1], 6);

    // Bounded idle check: no spurious completions with no requests
    got = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (complete_instr || complete_data || mem_en) got = 1'b1;
    end
    chk("quiet_when_no_req", 32'(got), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
